// File: rtl/instruction_fetch_unit.sv
// Fetch stage: turns the current PC into memory requests, tracks in-flight
// requests with a PC-tag FIFO and buffers returned words for decode.
module instruction_fetch_unit #(
  parameter int QUEUE_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pcAdvance,
  input  logic        flush,
  output logic        memReqValid,
  input  logic        memReqReady,
  output logic [31:0] memReqAddr,
  input  logic        memRespValid,
  input  logic [31:0] memRespData,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [31:0] instrPC,
  output logic        fetchFault
);

  localparam int QW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  logic [31:0]   q_pc_q   [QUEUE_DEPTH];
  logic [31:0]   q_pc_d   [QUEUE_DEPTH];
  logic [31:0]   q_word_q [QUEUE_DEPTH];
  logic [31:0]   q_word_d [QUEUE_DEPTH];
  logic [QW-1:0] wr_ptr_q, wr_ptr_d;
  logic [QW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   tag_q [MAX_OUTSTANDING];
  logic [31:0]   tag_d [MAX_OUTSTANDING];
  logic [TW-1:0] tag_wr_q, tag_wr_d;
  logic [TW-1:0] tag_rd_q, tag_rd_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] drop_count_q, drop_count_d;
  logic          fault_q, fault_d;

  logic aligned_s, room_s, issue_ok_s, accept_s, resp_s, push_s, pop_s;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    if (p == TW'(MAX_OUTSTANDING - 1)) begin
      return {TW{1'b0}};
    end else begin
      return p + TW'(1);
    end
  endfunction

  // Issue, response and consume qualifiers; the slot reservation keeps the queue from overflowing.
  always_comb begin
    aligned_s   = (pc[1:0] == 2'b00);
    room_s      = (SW'(outstanding_q) + SW'(count_q)) < SW'(QUEUE_DEPTH);
    issue_ok_s  = reset && !fault_q && (outstanding_q < OW'(MAX_OUTSTANDING)) && room_s;
    memReqValid = issue_ok_s && aligned_s && !flush;
    accept_s    = memReqValid && memReqReady;
    pcAdvance   = accept_s;
    memReqAddr  = pc;
    resp_s      = memRespValid && (outstanding_q != OW'(0));
    push_s      = resp_s && (drop_count_q == OW'(0)) && !flush;
    pop_s       = (count_q != CW'(0)) && instrReady && !flush;
    instrValid  = (count_q != CW'(0));
    instr       = q_word_q[rd_ptr_q];
    instrPC     = q_pc_q[rd_ptr_q];
    fetchFault  = fault_q;
  end

  // Next-state for tag FIFO, counters, queue and fault flag; flush overrides queue and drop state.
  always_comb begin
    q_pc_d        = q_pc_q;
    q_word_d      = q_word_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    tag_d         = tag_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    drop_count_d  = drop_count_q;
    outstanding_d = outstanding_q + OW'(accept_s) - OW'(resp_s);

    if (accept_s) begin
      tag_d[tag_wr_q] = pc;
      tag_wr_d        = tag_next(tag_wr_q);
    end else begin
      tag_wr_d = tag_wr_q;
    end

    if (resp_s) begin
      tag_rd_d = tag_next(tag_rd_q);
    end else begin
      tag_rd_d = tag_rd_q;
    end

    if (flush) begin
      drop_count_d = outstanding_q - OW'(resp_s);
    end else if (resp_s && (drop_count_q != OW'(0))) begin
      drop_count_d = drop_count_q - OW'(1);
    end else begin
      drop_count_d = drop_count_q;
    end

    if (flush) begin
      wr_ptr_d = {QW{1'b0}};
      rd_ptr_d = {QW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        q_pc_d[wr_ptr_q]   = tag_q[tag_rd_q];
        q_word_d[wr_ptr_q] = memRespData;
        wr_ptr_d           = wr_ptr_q + QW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + QW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end

    if (flush) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q || (issue_ok_s && !aligned_s);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc_q[i]   <= 32'h0;
        q_word_q[i] <= 32'h0;
      end
      for (int j = 0; j < MAX_OUTSTANDING; j++) begin
        tag_q[j] <= 32'h0;
      end
      wr_ptr_q      <= {QW{1'b0}};
      rd_ptr_q      <= {QW{1'b0}};
      count_q       <= {CW{1'b0}};
      tag_wr_q      <= {TW{1'b0}};
      tag_rd_q      <= {TW{1'b0}};
      outstanding_q <= {OW{1'b0}};
      drop_count_q  <= {OW{1'b0}};
      fault_q       <= 1'b0;
    end else begin
      q_pc_q        <= q_pc_d;
      q_word_q      <= q_word_d;
      tag_q         <= tag_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      outstanding_q <= outstanding_d;
      drop_count_q  <= drop_count_d;
      fault_q       <= fault_d;
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage directly downstream of the program counter register. Each cycle it turns the current PC into an instruction-memory request, tracks in-flight requests, and buffers returned words with their PC in a small queue for decode. Its `pcAdvance` output is the PC register's load enable, so the PC moves only when a fetch is actually accepted. A `flush` input discards everything buffered or in flight when the datapath redirects the PC.

## Interface

- `QUEUE_DEPTH`, default 4: instruction queue entries; power of two, ≥2.
- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unanswered memory requests; ≥1.

- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; low clears all state immediately.
- `pc` in 32: current PC from the program counter register.
- `pcAdvance` out 1: a request was accepted this cycle; the PC register loads its next value.
- `flush` in 1: discard the queue and all in-flight responses.
- `memReqValid` out 1: request valid.
- `memReqReady` in 1: memory accepts the request.
- `memReqAddr` out 32: request address, always equal to `pc`.
- `memRespValid` in 1: response word valid. Responses return in request order, at the earliest one cycle after acceptance, with no backpressure.
- `memRespData` in 32: response word.
- `instrValid` out 1: queue head is valid.
- `instrReady` in 1: decode consumes the head.
- `instr` out 32: head instruction word.
- `instrPC` out 32: PC of the head instruction.
- `fetchFault` out 1: sticky misaligned-PC indication.

## Operation

**State**
- Queue: `QUEUE_DEPTH` × {pc, word}, with read/write pointers and a count.
- PC-tag FIFO of depth `MAX_OUTSTANDING`.
- `outstanding` counter.
- `dropCount` counter.
- `fetchFault` flag.

**Issue**
- `memReqValid = !flush && !fetchFault && pc[1:0]==0 && outstanding < MAX_OUTSTANDING && (outstanding + count) < QUEUE_DEPTH`. The last term reserves a queue slot for every in-flight request, so the queue can never overflow.
- Accept is `memReqValid && memReqReady`. On accept, `pcAdvance = 1`, `pc` is pushed into the tag FIFO, and `outstanding` increments.
- `memReqReady` must not depend combinationally on `memReqValid`.

**Response**
- On `memRespValid`, the tag FIFO pops and `outstanding` decrements.
- If `dropCount > 0`, `dropCount` decrements and the word is discarded.
- Otherwise {tag, `memRespData`} is written to the queue tail.
- A response while `outstanding == 0` is a protocol error. It is ignored and the counters are unchanged.

**Consume**
- `instrValid = (count != 0)`.
- `instr` and `instrPC` are driven from the head entry.
- Pop on `instrValid && instrReady`.
- Push and pop in the same cycle leave `count` unchanged, including when the queue is full.

**Flush** (highest priority)
- `count`, pointers and `fetchFault` clear.
- `dropCount` loads the number of requests still in flight after this edge: `outstanding` minus 1 if a response arrives this cycle. That response is itself discarded.
- `memReqValid` is forced low, so no accept occurs in the flush cycle.
- A pop requested in the flush cycle is ignored.

**Fault**
- `pc[1:0] != 0` while the block is otherwise able to issue sets `fetchFault`.
- While set, issue is blocked. Queued and in-flight instructions still drain normally.
- Only `flush` or reset clears it.

**Reset values**
- All counters, pointers and queue storage are 0.
- `instrValid`, `instr`, `instrPC`, `fetchFault`, `memReqValid` and `pcAdvance` are 0.

## Timing

- `memReqValid`, `memReqAddr` and `pcAdvance` are combinational from `pc`, the current state, `flush` and `memReqReady`.
- `instrValid`, `instr` and `instrPC` are registered state. A response at edge t appears at the outputs after edge t; there is no bypass.
- Minimum latency is 2 cycles: accept in cycle n, response in n+1, `instrValid` in n+2.
- Sustained throughput is 1 instruction/cycle when memory latency is 1, `MAX_OUTSTANDING ≥ 2` and decode is always ready.
- `fetchFault` rises the cycle after the misaligned `pc` is seen.
- A flush takes effect at its edge. Issue resumes the next cycle from the new `pc`.
- Reset deassertion is synchronised externally; the first issue may occur in the first cycle after deassertion.

## Test plan

- **Streaming:** after reset, `pc`=0 advancing by 4, memory latency 1, `instrReady`=1. Expect `instrPC` = 0, 4, 8, … on consecutive cycles from cycle 2, `instr` matching the memory words, and `pcAdvance` high every cycle.
- **Backpressure:** `instrReady`=0 with memory always ready. Exactly `QUEUE_DEPTH` (4) requests are accepted, then `memReqValid` stays 0. Raising `instrReady` drains the queue in order with no loss or duplication.
- **Flush in flight:** two requests outstanding at latency 3, `flush` pulsed. `dropCount`=2, both responses are discarded, `instrValid` stays 0, and the next fetch from the new `pc`=0x100 emerges with `instrPC`=0x100.
- **Flush with coincident response:** `flush` in the same cycle as a response, with 1 outstanding. The response is dropped, `dropCount`=0, and the next response is enqueued.
- **Misaligned PC:** `pc`=0x2. No request is issued, `fetchFault`=1 the next cycle and stays high. `flush` clears it, and `pc`=0x8 then fetches normally.
- **Async reset mid-operation:** `reset` driven low between clock edges with the queue holding 3 entries. `instrValid`, `fetchFault` and all counters read 0 immediately, before the next edge.
